// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU datapath: widths, ALU opcodes and
// the writeback state encoding.
package cpu19_pkg;

  localparam int DATA_W = 19;
  localparam int REG_AW = 4;
  localparam int RES_W  = 2 * DATA_W;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_XOR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_NOT = 5'b01000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_flag_calc.sv
// Next-value computation for the Z/N/H flags from a captured ALU result.
// A multiply judges zero and sign over the full double-width product.
module wb_flag_calc
  import cpu19_pkg::*;
(
  input  logic [RES_W-1:0] res,
  input  logic             mul,
  output logic             z_next,
  output logic             n_next,
  output logic             h_next
);

  logic hi_nonzero;

  assign hi_nonzero = (res[RES_W-1:DATA_W] != '0);
  assign z_next     = mul ? (res == '0) : (res[DATA_W-1:0] == '0);
  assign n_next     = mul ? res[RES_W-1] : res[DATA_W-1];
  assign h_next     = mul & hi_nonzero;

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the 19-bit ALU: drives the single register-file
// write port and splits multiply products into low and high word writes.
module alu_writeback
  import cpu19_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RES_W-1:0]  in_result,
  input  logic [4:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_h,
  output logic              busy
);

  wb_state_t         state;
  logic [RES_W-1:0]  res_q;
  logic [REG_AW-1:0] rd_q;
  logic              mul_q;
  logic [REG_AW-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  logic              accept;
  logic              writing;
  logic              lo_done;
  logic [REG_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              z_next;
  logic              n_next;
  logic              h_next;

  wb_flag_calc u_flag_calc (
    .res    (res_q),
    .mul    (mul_q),
    .z_next (z_next),
    .n_next (n_next),
    .h_next (h_next)
  );

  // A new result may only enter WR_LO when the pending low write completes
  // this same cycle, so nothing is overwritten before reaching the file.
  assign in_ready = rst_n & ~rf_stall &
                    ((state == IDLE) | ((state == WR_LO) & ~mul_q));
  assign accept   = in_valid & in_ready;
  assign writing  = (state == WR_LO) | (state == WR_HI);
  assign lo_done  = (state == WR_LO) & ~rf_stall;
  assign busy     = (state != IDLE);

  assign wr_addr  = (state == WR_HI) ? rd_q + REG_AW'(1) : rd_q;
  assign wr_data  = (state == WR_HI) ? res_q[RES_W-1:DATA_W] : res_q[DATA_W-1:0];

  // Address and data follow captured state only; idle cycles replay the last write.
  assign rf_we    = rst_n & ~rf_stall & writing;
  assign rf_waddr = rf_we ? wr_addr : last_addr;
  assign rf_wdata = rf_we ? wr_data : last_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      res_q     <= '0;
      rd_q      <= '0;
      mul_q     <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_h    <= 1'b0;
    end else begin
      if (rf_we) begin
        last_addr <= wr_addr;
        last_data <= wr_data;
      end
      if (lo_done) begin
        flag_z <= z_next;
        flag_n <= n_next;
        flag_h <= h_next;
      end
      if (accept) begin
        res_q <= in_result;
        rd_q  <= in_rd;
        mul_q <= (in_opcode == OP_MUL);
      end
      case (state)
        IDLE: begin
          if (accept) state <= WR_LO;
        end
        WR_LO: begin
          if (!rf_stall) begin
            if (mul_q)       state <= WR_HI;
            else if (accept) state <= WR_LO;
            else             state <= IDLE;
          end
        end
        WR_HI: begin
          if (!rf_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed-vector bench for alu_writeback: reset, back-to-back writes,
// multiply split with address wrap, stalls and reset during a multiply.
module tb_alu_writeback;
  import cpu19_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [RES_W-1:0]  in_result;
  logic [4:0]        in_opcode;
  logic [REG_AW-1:0] in_rd;
  logic              rf_stall;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              flag_z;
  logic              flag_n;
  logic              flag_h;
  logic              busy;

  int compared;
  int mismatched;

  alu_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .rf_stall  (rf_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_h    (flag_h),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] opcode,
                               input logic [RES_W-1:0] result,
                               input logic [REG_AW-1:0] rd, input logic stall);
    in_valid  = valid;
    in_opcode = opcode;
    in_result = result;
    in_rd     = rd;
    rf_stall  = stall;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic we,
                            input logic [REG_AW-1:0] addr, input logic [DATA_W-1:0] data);
    checkOutput({tag, "_we"}, rf_we, we);
    checkOutput({tag, "_addr"}, rf_waddr, addr);
    checkOutput({tag, "_data"}, rf_wdata, data);
  endtask

  task automatic checkFlags(input string tag, input logic z, input logic n, input logic h);
    checkOutput({tag, "_z"}, flag_z, z);
    checkOutput({tag, "_n"}, flag_n, n);
    checkOutput({tag, "_h"}, flag_h, h);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    applyStimulus(1'b1, OP_ADD, 38'h1234, 4'd7, 1'b0);

    // Reset held for three edges with a valid result offered
    repeat (3) nextCycle();
    @(negedge clk);
    checkWrite("rst", 1'b0, 4'd0, 19'h0);
    checkOutput("rst_ready", in_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkFlags("rst", 1'b0, 1'b0, 1'b0);

    nextCycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, OP_ADD, 38'h0, 4'd0, 1'b0);
    @(negedge clk);
    checkOutput("idle_ready", in_ready, 1'b1);
    checkOutput("idle_busy", busy, 1'b0);

    // Back-to-back ADD then SUB
    nextCycle();
    applyStimulus(1'b1, OP_ADD, 38'h5, 4'd3, 1'b0);
    nextCycle();
    applyStimulus(1'b1, OP_SUB, 38'h0, 4'd4, 1'b0);
    @(negedge clk);
    checkWrite("b2b_w1", 1'b1, 4'd3, 19'h5);
    checkOutput("b2b_ready", in_ready, 1'b1);
    nextCycle();
    applyStimulus(1'b0, OP_ADD, 38'h0, 4'd0, 1'b0);
    @(negedge clk);
    checkWrite("b2b_w2", 1'b1, 4'd4, 19'h0);
    checkFlags("b2b_mid", 1'b0, 1'b0, 1'b0);
    nextCycle();
    @(negedge clk);
    checkWrite("b2b_idle", 1'b0, 4'd4, 19'h0);
    checkFlags("b2b_end", 1'b1, 1'b0, 1'b0);
    checkOutput("b2b_busy", busy, 1'b0);

    // Multiply to r15: high word wraps to r0
    nextCycle();
    applyStimulus(1'b1, OP_MUL, {19'h00002, 19'h7FFFF}, 4'd15, 1'b0);
    nextCycle();
    applyStimulus(1'b1, OP_ADD, 38'h77, 4'd9, 1'b0);
    @(negedge clk);
    checkWrite("mul_lo", 1'b1, 4'd15, 19'h7FFFF);
    checkOutput("mul_lo_ready", in_ready, 1'b0);
    nextCycle();
    applyStimulus(1'b0, OP_ADD, 38'h0, 4'd0, 1'b0);
    @(negedge clk);
    checkWrite("mul_hi", 1'b1, 4'd0, 19'h00002);
    checkOutput("mul_hi_ready", in_ready, 1'b0);
    checkFlags("mul", 1'b0, 1'b0, 1'b1);
    nextCycle();
    @(negedge clk);
    checkWrite("mul_idle", 1'b0, 4'd0, 19'h00002);
    checkOutput("mul_ready_back", in_ready, 1'b1);
    checkOutput("mul_busy", busy, 1'b0);

    // Stall in IDLE with a valid result: nothing may be accepted
    applyStimulus(1'b1, OP_ADD, 38'h3, 4'd6, 1'b1);
    @(negedge clk);
    checkOutput("idle_stall_ready", in_ready, 1'b0);
    nextCycle();
    applyStimulus(1'b0, OP_ADD, 38'h0, 4'd0, 1'b0);
    @(negedge clk);
    checkOutput("idle_stall_busy", busy, 1'b0);
    checkOutput("idle_stall_we", rf_we, 1'b0);

    // Three stalled WR_LO cycles, then a single write
    nextCycle();
    applyStimulus(1'b1, OP_ADD, 38'h40000, 4'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b0, OP_ADD, 38'h0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_we", i), rf_we, 1'b0);
      checkOutput($sformatf("stall%0d_ready", i), in_ready, 1'b0);
      checkOutput($sformatf("stall%0d_busy", i), busy, 1'b1);
      checkOutput($sformatf("stall%0d_n", i), flag_n, 1'b0);
      nextCycle();
    end
    rf_stall = 1'b0;
    @(negedge clk);
    checkWrite("stall_wr", 1'b1, 4'd2, 19'h40000);
    checkOutput("stall_wr_n", flag_n, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("stall_done_we", rf_we, 1'b0);
    checkFlags("stall_done", 1'b0, 1'b1, 1'b0);
    checkOutput("stall_done_busy", busy, 1'b0);

    // Reset during the WR_LO cycle of a multiply
    nextCycle();
    applyStimulus(1'b1, OP_MUL, {19'h00001, 19'h00003}, 4'd5, 1'b0);
    nextCycle();
    applyStimulus(1'b0, OP_ADD, 38'h0, 4'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstmul_we_lo", rf_we, 1'b0);
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkWrite("rstmul_after", 1'b0, 4'd0, 19'h0);
    checkOutput("rstmul_busy", busy, 1'b0);
    checkFlags("rstmul", 1'b0, 1'b0, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("rstmul_no_hi", rf_we, 1'b0);
    checkOutput("rstmul_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Writeback stage directly downstream of the 19-bit ALU.
- Consumes the ALU's 38-bit result with a valid/ready handshake and drives the single register-file write port.
- A multiply result is written as two beats: the low word to rd, then the high word to rd+1.
- Maintains the architectural Z/N/H flags.

Parameters:
- DATA_W, 19, architectural word width; ALU result width is 2*DATA_W.
- REG_AW, 4, register-file address width (16 registers).
- OP_MUL, 5'b00010, opcode whose result needs a high-word write.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept a result this cycle
- in_result  in  2*DATA_W  ALU result
- in_opcode  in  5  opcode that produced in_result
- in_rd  in  REG_AW  destination register
- rf_stall  in  1  register file cannot accept a write this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  DATA_W  write data
- flag_z  out  1  zero flag
- flag_n  out  1  negative (sign) flag
- flag_h  out  1  high-word-nonzero flag (multiply overflow)
- busy  out  1  stage holds an unwritten result

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
- Reset values (while rst_n=0 and on the first edge after it):
  - state=IDLE
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - flag_z=flag_n=flag_h=0
  - busy=0, in_ready=0
- Reset mid-operation: any pending low or high write is discarded; no rf_we pulse after reset.
- Capture registers: res_q (2*DATA_W), rd_q, mul_q (in_opcode==OP_MUL).
- State machine: IDLE, WR_LO, WR_HI.
  - in_ready = rst_n & !rf_stall & (state==IDLE | (state==WR_LO & !mul_q)).
  - Accept = in_valid & in_ready. On accept, capture res_q, rd_q, mul_q and go to WR_LO.
  - IDLE: rf_we=0. On accept go to WR_LO.
  - WR_LO: rf_we = !rf_stall, rf_waddr = rd_q, rf_wdata = res_q[DATA_W-1:0].
    - If rf_stall: hold state.
    - Else if mul_q: go to WR_HI.
    - Else if accept (new capture): stay in WR_LO.
    - Else: go to IDLE.
  - WR_HI: rf_we = !rf_stall, rf_waddr = rd_q+1 (mod 2^REG_AW; 15 wraps to 0), rf_wdata = res_q[2*DATA_W-1:DATA_W]. On !rf_stall go to IDLE.
- Output timing: rf_we, rf_waddr and rf_wdata are driven only from registered state; there is no combinational path from in_* to rf_*. When rf_we=0, rf_waddr and rf_wdata hold their last values.
- Latency and throughput:
  - Accept at edge N gives the low write in cycle N+1.
  - Non-multiply: back-to-back at 1 result per cycle.
  - Multiply: 2 cycles, and in_ready=0 during its WR_LO and WR_HI.
- Flags are registered and update on the edge that completes the WR_LO write (WR_LO & !rf_stall):
  - flag_z = (mul_q ? res_q==0 : res_q[DATA_W-1:0]==0)
  - flag_n = mul_q ? res_q[2*DATA_W-1] : res_q[DATA_W-1]
  - flag_h = mul_q & (res_q[2*DATA_W-1:DATA_W] != 0)
  - Flags are never updated in WR_HI or while stalled.
- busy = (state != IDLE).
- Simultaneous events:
  - rf_stall asserted together with in_valid: nothing is accepted.
  - Accept in WR_LO takes effect only with a completing write, so no result is overwritten before it is written.

Decomposition:
- Shared package cpu19_pkg holds:
  - DATA_W=19, REG_AW=4
  - opcode constants OP_ADD..OP_NOT (5-bit), including OP_MUL
  - the wb_state_t enum {IDLE, WR_LO, WR_HI}
- One natural sub-module: wb_flag_calc. It is combinational, takes res_q and mul_q, and produces next Z/N/H.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> rf_we=0, in_ready=0, all flags 0; release -> in_ready=1 in IDLE.
- Back-to-back non-multiply: ADD result 38'h5 to rd=3, then SUB result 0 to rd=4 on consecutive cycles -> rf_we two consecutive cycles, (3, 19'h5) then (4, 0); flag_z=1 after the second write.
- Multiply: OP_MUL result {19'h00002, 19'h7FFFF} to rd=15 -> (15, 19'h7FFFF), then (0, 19'h00002) from address wrap; flag_h=1, flag_n=0, flag_z=0; in_ready=0 for 2 cycles.
- Stall: rf_stall=1 for 3 cycles during WR_LO of result 19'h40000 to rd=2 -> rf_we=0 and in_ready=0 while stalled; a single write (2, 19'h40000) after release; flag_n=1 only after that write.
- Reset mid-multiply: assert rst_n=0 in the WR_LO cycle of a multiply -> no WR_HI write occurs, state=IDLE, flags=0.
